// File: rtl/tft_pic_ctrl.sv
// ---------------------------------------------------------------------------
// tft_pic_ctrl
// Picture placement and motion controller for a TFT raster. A picture of
// IMAGE_W x IMAGE_H pixels is stored in an external ROM. This block generates
// the ROM read enable and address while the raster passes over the picture
// window. Between frames it optionally moves the picture, bouncing it off the
// screen edges.
//
// Ports
//   tft_clk     : pixel clock, all logic on its rising edge
//   sys_rst     : synchronous active-high reset
//   pix_x/pix_y : current raster position (>= H_VALID/V_VALID when blanking)
//   move_en     : enables picture motion
//   speed       : pixels moved per motion step on each axis
//   rd_en       : ROM read enable (combinational window decode)
//   rom_addr    : ROM read address
//   image_valid : ROM data is the current pixel (rd_en delayed by ROM latency)
//   img_x/img_y : picture top-left origin
//   frame_done  : one-cycle pulse while the position update executes
// ---------------------------------------------------------------------------
module tft_pic_ctrl #(
  parameter logic [9:0]  H_VALID    = 10'd480,
  parameter logic [9:0]  V_VALID    = 10'd272,
  parameter logic [9:0]  IMAGE_W    = 10'd100,
  parameter logic [9:0]  IMAGE_H    = 10'd100,
  parameter logic [13:0] IMAGE_SIZE = 14'd10000,
  parameter logic [7:0]  FRAME_DIV  = 8'd1
) (
  input  logic        tft_clk,
  input  logic        sys_rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        move_en,
  input  logic [2:0]  speed,
  output logic        rd_en,
  output logic [13:0] rom_addr,
  output logic        image_valid,
  output logic [9:0]  img_x,
  output logic [9:0]  img_y,
  output logic        frame_done
);

  // Bounce limits, kept in 11 bits so position sums can never wrap.
  localparam logic [10:0] X_MIN  = 11'd1;
  localparam logic [10:0] X_MAX  = {1'b0, H_VALID} - {1'b0, IMAGE_W};
  localparam logic [10:0] Y_MIN  = 11'd0;
  localparam logic [10:0] Y_MAX  = {1'b0, V_VALID} - {1'b0, IMAGE_H};
  localparam logic [9:0]  X_INIT = (H_VALID - IMAGE_W) / 10'd2;
  localparam logic [9:0]  Y_INIT = (V_VALID - IMAGE_H) / 10'd2;

  typedef enum logic {ST_SCAN, ST_UPDATE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_in_update;
  logic        w_frame_end;
  logic        w_step;
  logic [7:0]  r_frame_cnt;
  logic [9:0]  r_img_x;
  logic [9:0]  r_img_y;
  logic        r_dir_x;       // 1 = moving right
  logic        r_dir_y;       // 1 = moving down
  logic [9:0]  w_img_x_next;
  logic [9:0]  w_img_y_next;
  logic        w_dir_x_next;
  logic        w_dir_y_next;
  logic [10:0] w_speed11;
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;
  logic [10:0] w_px1;
  logic        w_x_in;
  logic        w_y_in;
  logic [13:0] r_rom_addr;
  logic        r_image_valid;

  assign w_frame_end = (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);

  // FSM: state register
  always_ff @(posedge tft_clk) begin
    if (sys_rst) r_state <= ST_SCAN;
    else         r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SCAN:   if (w_frame_end) w_state_next = ST_UPDATE;
      ST_UPDATE: w_state_next = ST_SCAN;
      default:   w_state_next = ST_SCAN;
    endcase
  end

  // FSM: outputs (decoded from the state register, so frame_done is glitch-free)
  always_comb begin
    w_in_update = 1'b0;
    frame_done  = 1'b0;
    if (r_state == ST_UPDATE) begin
      w_in_update = 1'b1;
      frame_done  = 1'b1;
    end
  end

  // Motion happens only on the last frame of each FRAME_DIV group.
  assign w_step = w_in_update && move_en && (r_frame_cnt == FRAME_DIV - 8'd1);

  always_ff @(posedge tft_clk) begin
    if (sys_rst) begin
      r_frame_cnt <= 8'd0;
    end else if (w_in_update) begin
      if (!move_en || (r_frame_cnt == FRAME_DIV - 8'd1)) r_frame_cnt <= 8'd0;
      else                                               r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign w_speed11 = {8'd0, speed};
  assign w_x_sum   = {1'b0, r_img_x} + w_speed11;
  assign w_y_sum   = {1'b0, r_img_y} + w_speed11;

  // Bounce arithmetic. A zero speed skips the edge compares entirely so a
  // picture parked on an edge does not flip direction.
  always_comb begin
    w_img_x_next = r_img_x;
    w_img_y_next = r_img_y;
    w_dir_x_next = r_dir_x;
    w_dir_y_next = r_dir_y;
    if (speed != 3'd0) begin
      if (r_dir_x) begin
        if (w_x_sum >= X_MAX) begin
          w_img_x_next = X_MAX[9:0];
          w_dir_x_next = 1'b0;
        end else begin
          w_img_x_next = w_x_sum[9:0];
        end
      end else if ({1'b0, r_img_x} <= X_MIN + w_speed11) begin
        w_img_x_next = X_MIN[9:0];
        w_dir_x_next = 1'b1;
      end else begin
        w_img_x_next = r_img_x - {7'd0, speed};
      end

      if (r_dir_y) begin
        if (w_y_sum >= Y_MAX) begin
          w_img_y_next = Y_MAX[9:0];
          w_dir_y_next = 1'b0;
        end else begin
          w_img_y_next = w_y_sum[9:0];
        end
      end else if ({1'b0, r_img_y} <= Y_MIN + w_speed11) begin
        w_img_y_next = Y_MIN[9:0];
        w_dir_y_next = 1'b1;
      end else begin
        w_img_y_next = r_img_y - {7'd0, speed};
      end
    end
  end

  always_ff @(posedge tft_clk) begin
    if (sys_rst) begin
      r_img_x <= X_INIT;
      r_img_y <= Y_INIT;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_step) begin
      r_img_x <= w_img_x_next;
      r_img_y <= w_img_y_next;
      r_dir_x <= w_dir_x_next;
      r_dir_y <= w_dir_y_next;
    end
  end

  // Window decode. The x window starts one column early to absorb the ROM
  // read latency; comparing pix_x+1 against img_x avoids an underflow.
  assign w_px1  = {1'b0, pix_x} + 11'd1;
  assign w_x_in = (w_px1 >= {1'b0, r_img_x}) &&
                  (w_px1 <  {1'b0, r_img_x} + {1'b0, IMAGE_W});
  assign w_y_in = ({1'b0, pix_y} >= {1'b0, r_img_y}) &&
                  ({1'b0, pix_y} <  {1'b0, r_img_y} + {1'b0, IMAGE_H});
  assign rd_en  = w_x_in && w_y_in;

  // The UPDATE cycle resynchronises the address to the picture start.
  always_ff @(posedge tft_clk) begin
    if (sys_rst) begin
      r_rom_addr <= 14'd0;
    end else if (w_in_update) begin
      r_rom_addr <= 14'd0;
    end else if (rd_en) begin
      if (r_rom_addr == IMAGE_SIZE - 14'd1) r_rom_addr <= 14'd0;
      else                                  r_rom_addr <= r_rom_addr + 14'd1;
    end
  end

  always_ff @(posedge tft_clk) begin
    if (sys_rst) r_image_valid <= 1'b0;
    else         r_image_valid <= rd_en;
  end

  assign rom_addr    = r_rom_addr;
  assign image_valid = r_image_valid;
  assign img_x       = r_img_x;
  assign img_y       = r_img_y;

endmodule

// File: tb/tb_tft_pic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tft_pic_ctrl
// Self-checking bench for tft_pic_ctrl. Two instances share all inputs: one
// with FRAME_DIV=1 and one with FRAME_DIV=4. Every frame_end pushes the
// expected picture positions of both instances to a scoreboard; a monitor
// pops and compares them once the update has taken effect.
// ---------------------------------------------------------------------------
module tb_tft_pic_ctrl;

  logic        tft_clk = 1'b0;
  logic        sys_rst;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        move_en;
  logic [2:0]  speed;
  logic        rd_en,  rd_en4;
  logic [13:0] rom_addr, rom_addr4;
  logic        image_valid, image_valid4;
  logic [9:0]  img_x, img_y, img_x4, img_y4;
  logic        frame_done, frame_done4;

  int checks = 0;
  int errors = 0;

  always #5 tft_clk = ~tft_clk;

  tft_pic_ctrl #(.FRAME_DIV(8'd1)) dut (
    .tft_clk(tft_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
    .move_en(move_en), .speed(speed), .rd_en(rd_en), .rom_addr(rom_addr),
    .image_valid(image_valid), .img_x(img_x), .img_y(img_y),
    .frame_done(frame_done)
  );

  tft_pic_ctrl #(.FRAME_DIV(8'd4)) dut4 (
    .tft_clk(tft_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
    .move_en(move_en), .speed(speed), .rd_en(rd_en4), .rom_addr(rom_addr4),
    .image_valid(image_valid4), .img_x(img_x4), .img_y(img_y4),
    .frame_done(frame_done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model, index 0 = FRAME_DIV 1, index 1 = FRAME_DIV 4
  int m_x[2], m_y[2], m_dx[2], m_dy[2], m_cnt[2];
  int m_div[2] = '{1, 4};

  typedef struct {int x0; int y0; int x1; int y1;} exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 190; m_y[i] = 86; m_dx[i] = 1; m_dy[i] = 1; m_cnt[i] = 0;
    end
  endtask

  task automatic model_frame(input bit mv, input int sp);
    for (int i = 0; i < 2; i++) begin
      if (!mv) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] != m_div[i] - 1) begin
        m_cnt[i]++;
      end else begin
        m_cnt[i] = 0;
        if (sp != 0) begin
          if (m_dx[i] == 1) begin
            if (m_x[i] + sp >= 380) begin m_x[i] = 380; m_dx[i] = 0; end
            else m_x[i] += sp;
          end else begin
            if (m_x[i] <= 1 + sp) begin m_x[i] = 1; m_dx[i] = 1; end
            else m_x[i] -= sp;
          end
          if (m_dy[i] == 1) begin
            if (m_y[i] + sp >= 172) begin m_y[i] = 172; m_dy[i] = 0; end
            else m_y[i] += sp;
          end else begin
            if (m_y[i] <= sp) begin m_y[i] = 0; m_dy[i] = 1; end
            else m_y[i] -= sp;
          end
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.x0 = m_x[0]; e.y0 = m_y[0]; e.x1 = m_x[1]; e.y1 = m_y[1];
    sb.push_back(e);
  endtask

  // Positions settle on the edge ending the UPDATE cycle, so compare one
  // negedge after frame_done was seen.
  logic fd_seen = 1'b0;
  always @(negedge tft_clk) begin
    if (fd_seen) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_img_x", img_x, e.x0);
        check("sb_img_y", img_y, e.y0);
        check("sb_img_x4", img_x4, e.x1);
        check("sb_img_y4", img_y4, e.y1);
        $display("frame: img=(%0d,%0d) img4=(%0d,%0d)", img_x, img_y, img_x4, img_y4);
      end
    end
    fd_seen <= frame_done;
  end

  task automatic do_frame(input bit mv, input int sp);
    @(posedge tft_clk); #1;
    move_en = mv; speed = sp[2:0];
    pix_x = 10'd479; pix_y = 10'd271;
    model_frame(mv, sp);
    push_exp();
    @(negedge tft_clk);
    check("fd_early", frame_done, 0);
    @(posedge tft_clk); #1;
    pix_x = 10'd480; pix_y = 10'd272;
    @(negedge tft_clk);
    check("fd_pulse", frame_done, 1);
    check("fd4_pulse", frame_done4, 1);
    @(negedge tft_clk);
    check("fd_after", frame_done, 0);
    check("rom_resync", rom_addr, 0);
  endtask

  task automatic do_reset();
    @(posedge tft_clk); #1;
    sys_rst = 1'b1; move_en = 1'b0; speed = 3'd0;
    @(posedge tft_clk); #1;
    sys_rst = 1'b0;
    model_reset();
  endtask

  // Walk one axis to a target position moving in a target direction.
  task automatic drive_to(input bit is_y, input int t, input int tdir);
    int p, d, s;
    for (int k = 0; k < 400; k++) begin
      p = is_y ? m_y[0] : m_x[0];
      d = is_y ? m_dy[0] : m_dx[0];
      if (p == t && d == tdir) break;
      if (d == tdir && ((tdir == 1) ? (t > p) : (t < p)))
        s = ((t > p ? t - p : p - t) < 7) ? (t > p ? t - p : p - t) : 7;
      else
        s = 7;
      do_frame(1'b1, s);
    end
    check(is_y ? "goto_y" : "goto_x", is_y ? img_y : img_x, t);
  endtask

  task automatic scan_window(input int stop_at, output int n_rd, output int n_mis,
                             output int n_iv, output bit stopped);
    int x0, y0;
    logic prev_rd;
    logic exp_rd;
    x0 = (m_x[0] >= 3) ? m_x[0] - 3 : 0;
    y0 = (m_y[0] >= 2) ? m_y[0] - 2 : 0;
    prev_rd = 1'b0; n_rd = 0; n_mis = 0; n_iv = 0; stopped = 1'b0;
    for (int py = y0; py <= m_y[0] + 101; py++) begin
      for (int px = x0; px <= m_x[0] + 101; px++) begin
        @(posedge tft_clk); #1;
        pix_x = px[9:0]; pix_y = py[9:0];
        @(negedge tft_clk);
        exp_rd = (px + 1 >= m_x[0]) && (px + 1 < m_x[0] + 100) &&
                 (py >= m_y[0]) && (py < m_y[0] + 100);
        if (rd_en !== exp_rd) n_mis++;
        if (image_valid !== prev_rd) n_iv++;
        prev_rd = rd_en;
        if (rd_en) n_rd++;
        if (stop_at >= 0 && int'(rom_addr) == stop_at) begin
          stopped = 1'b1;
          return;
        end
      end
      @(posedge tft_clk); #1;
      pix_x = 10'd480;
      @(negedge tft_clk);
      if (image_valid !== prev_rd) n_iv++;
      prev_rd = rd_en;
    end
    @(posedge tft_clk); #1;
    pix_x = 10'd480; pix_y = 10'd272;
    @(negedge tft_clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rd, n_mis, n_iv;
    bit stopped;

    sys_rst = 1'b1; pix_x = 10'd480; pix_y = 10'd272; move_en = 1'b0; speed = 3'd0;
    model_reset();
    repeat (3) @(posedge tft_clk);
    @(negedge tft_clk);
    check("rst_img_x", img_x, 190);
    check("rst_img_y", img_y, 86);
    check("rst_rom", rom_addr, 0);
    check("rst_iv", image_valid, 0);
    check("rst_fd", frame_done, 0);
    check("rst_img_x4", img_x4, 190);
    check("rst_rom4", rom_addr4, 0);
    @(posedge tft_clk); #1;
    sys_rst = 1'b0;

    // Static picture: window placement, read count and address wrap
    scan_window(-1, n_rd, n_mis, n_iv, stopped);
    check("win_rd_pattern", n_mis, 0);
    check("win_rd_count", n_rd, 10000);
    check("win_iv_delay", n_iv, 0);
    check("win_rom_wrap", rom_addr, 0);
    check("idle_rd4", rd_en4, 0);
    do_frame(1'b0, 3);
    check("static_x", img_x, 190);

    // Constant motion at speed 3
    for (int k = 1; k <= 3; k++) begin
      do_frame(1'b1, 3);
      check("mv3_x", img_x, 190 + 3 * k);
      check("mv3_y", img_y, 86 + 3 * k);
    end
    check("div4_hold", img_x4, 190);

    // Zero speed never moves
    repeat (4) do_frame(1'b1, 0);
    check("spd0_x", img_x, 199);
    check("spd0_y", img_y, 95);

    // FRAME_DIV=4 cadence and counter clear on move_en=0
    do_reset();
    repeat (3) do_frame(1'b1, 1);
    check("div4_3fr", img_x4, 190);
    do_frame(1'b1, 1);
    check("div4_4fr", img_x4, 191);
    repeat (2) do_frame(1'b1, 1);
    do_frame(1'b0, 1);
    repeat (3) do_frame(1'b1, 1);
    check("div4_clr", img_x4, 191);
    do_frame(1'b1, 1);
    check("div4_step2", img_x4, 192);
    check("div1_x", img_x, 200);

    // Reset mid-window with rom_addr = 4321
    scan_window(4321, n_rd, n_mis, n_iv, stopped);
    check("rst_stop_hit", stopped, 1);
    check("rst_stop_pat", n_mis, 0);
    sys_rst = 1'b1;
    @(posedge tft_clk); #1;
    sys_rst = 1'b0;
    model_reset();
    @(negedge tft_clk);
    check("mrst_rom", rom_addr, 0);
    check("mrst_iv", image_valid, 0);
    check("mrst_x", img_x, 190);
    check("mrst_y", img_y, 86);
    pix_x = 10'd480; pix_y = 10'd272;
    do_frame(1'b1, 3);

    // Reset landing in the UPDATE cycle
    @(posedge tft_clk); #1;
    move_en = 1'b1; speed = 3'd3; pix_x = 10'd479; pix_y = 10'd271;
    model_reset();
    push_exp();
    @(posedge tft_clk); #1;
    sys_rst = 1'b1; pix_x = 10'd480; pix_y = 10'd272;
    @(negedge tft_clk);
    check("urst_fd_in", frame_done, 1);
    @(posedge tft_clk); #1;
    sys_rst = 1'b0;
    @(negedge tft_clk);
    check("urst_fd_out", frame_done, 0);
    check("urst_x", img_x, 190);

    // Address resynchronisation has priority over the increment
    scan_window(50, n_rd, n_mis, n_iv, stopped);
    check("part_stop_hit", stopped, 1);
    do_frame(1'b0, 0);

    // Right edge bounce
    do_reset();
    drive_to(1'b0, 378, 1);
    do_frame(1'b1, 5);
    check("xr_clamp", img_x, 380);
    do_frame(1'b1, 5);
    check("xr_back", img_x, 375);

    // Top edge bounce
    do_reset();
    drive_to(1'b1, 2, 0);
    do_frame(1'b1, 7);
    check("yt_clamp", img_y, 0);
    do_frame(1'b1, 7);
    check("yt_back", img_y, 7);

    // Left edge bounce
    drive_to(1'b0, 4, 0);
    do_frame(1'b1, 7);
    check("xl_clamp", img_x, 1);
    do_frame(1'b1, 7);
    check("xl_back", img_x, 8);

    repeat (3) @(negedge tft_clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
